mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM->WB pipeline register plus writeback stage of the 5-stage MIPS core.
//  Captures the MEM-stage result bus and the data-SRAM read word, performs load
//  byte/half selection and extension, and drives the regfile write port.
//  Also drives the WB->ID bypass bus and the debug trace outputs.
//  Sits between the MEM stage and regfile; it is the lowest-priority bypass source.
// PARAMETERS
//  MEM_TO_WB_WD  75  width of mem_to_wb_bus = {pc[31:0],rf_we,rf_waddr[4:0],rf_wdata[31:0],load_op[2:0],addr_lo[1:0]}
//  WB_TO_ID_WD   38  width of wb_to_id_bus = {wb_we,wb_waddr[4:0],wb_wdata[31:0]}
// PORTS
//  clk                clk   in   1    core clock; all state updates on rising edge
//  rst                in    1    synchronous, active-high reset
//  stall              in    6    pipeline stall vector; bit4 = MEM stalled, bit5 = WB stalled
//  flush              in    1    exception flush; kills the instruction entering WB
//  mem_to_wb_bus      in    MEM_TO_WB_WD  MEM-stage result (fields above)
//  data_sram_rdata    in    32   load data; valid only in the first cycle an instr is in WB
//  rf_we              out   1    regfile write enable
//  rf_waddr           out   5    regfile write address
//  rf_wdata           out   32   regfile write data (after load extension)
//  wb_to_id_bus       out   WB_TO_ID_WD   {rf_we,rf_waddr,rf_wdata}, same cycle as write port
//  debug_wb_pc        out   32   PC of the instruction in WB
//  debug_wb_rf_wen    out   4    {4{rf_we}}
//  debug_wb_rf_wnum   out   5    = rf_waddr
//  debug_wb_rf_wdata  out   32   = rf_wdata
// BEHAVIOUR
//  - Pipeline register update at posedge clk, priority order:
//    1 rst: all fields zero (pc=0, rf_we=0, load_op=0); first_cyc=0; rdata_hold=0
//    2 flush: load bubble (all fields zero)
//    3 stall[4]=1 & stall[5]=0: load bubble
//    4 stall[4]=0: capture mem_to_wb_bus; first_cyc<=1
//    5 stall[5]=1 (otherwise): hold all fields; first_cyc<=0
//  - Load-data hold: first_cyc=1 marks the first WB cycle of a captured instr.
//    In that cycle the stage uses data_sram_rdata directly and latches it into
//    rdata_hold; while first_cyc=0 it uses rdata_hold. Data stays stable across WB stalls.
//  - Latency: an instr's bus is visible on rf_*/wb_to_id_bus 1 cycle after capture;
//    the regfile commits it at the following edge.
//  - Load extension, on load_op (lo = addr_lo, w = selected word):
//    000 none: rf_wdata = bus rf_wdata
//    001 lb: sign-extend byte w[8*lo+7 : 8*lo]
//    010 lbu: zero-extend that byte
//    011 lh: sign-extend half w[16*lo[1]+15 : 16*lo[1]]; lo[0] ignored (EX traps misalignment)
//    100 lhu: zero-extend that half
//    101 lw: w as-is; lo ignored
//    110/111: treated as 000
//  - All outputs combinational from registered state; no combinational path from
//    mem_to_wb_bus to any output.
//  - rf_we = registered rf_we; waddr=0 passes through unchanged (regfile discards it;
//    ID read of r0 wins over bypass). Trace still reports it.
//  - Bubble: rf_we=0, debug_wb_pc=0, debug_wb_rf_wen=0.
//  - Reset mid-stall: rst wins; outputs go to the bubble state on the next edge.
//  - flush while stall[5]=1: flush wins; WB instr discarded.
// TESTING
//  1 rst=1 two cycles -> rf_we=0, debug_wb_pc=0, wb_to_id_bus=0.
//  2 ALU op pc=0xBFC00010, we=1, waddr=8, wdata=0x1234 -> next cycle rf_we=1, waddr=8,
//    rf_wdata=0x1234, wb_to_id_bus={1,8,0x1234}, debug_wb_rf_wen=4'hF.
//  3 loads, rdata=0x80FF7F01: lb lo=3 -> 0xFFFFFF80; lbu lo=1 -> 0x7F;
//    lh lo=2 -> 0xFFFF80FF; lhu lo=0 -> 0x7F01; lw -> 0x80FF7F01.
//  4 lw captured, stall[5]=1 three cycles, rdata changes to 0xDEADBEEF after cycle 1
//    -> rf_wdata stays the first-cycle value and pc/waddr hold throughout.
//  5 stall[4]=1, stall[5]=0 -> next cycle bubble (rf_we=0, pc=0);
//    flush=1 with valid input -> bubble.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register and writeback stage.
// Selects and extends load data, drives the regfile port, bypass bus and trace.
module mem_wb_stage #(
  parameter int MEM_TO_WB_WD = 75,
  parameter int WB_TO_ID_WD  = 38
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic                    flush,
  input  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [31:0]             rf_wdata,
  output logic [WB_TO_ID_WD-1:0]  wb_to_id_bus,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata
);

  logic [31:0] pc_q;
  logic        we_q;
  logic [4:0]  waddr_q;
  logic [31:0] wdata_q;
  logic [2:0]  op_q;
  logic [1:0]  lo_q;
  logic        first_q;
  logic [31:0] hold_q;

  logic        unused_stall;
  assign unused_stall = ^stall[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      lo_q    <= '0;
      first_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      // SRAM data is only valid on the first WB cycle; keep it for stalls
      if (first_q) hold_q <= data_sram_rdata;
      if (flush || (stall[4] && !stall[5])) begin
        pc_q    <= '0;
        we_q    <= 1'b0;
        waddr_q <= '0;
        wdata_q <= '0;
        op_q    <= '0;
        lo_q    <= '0;
        first_q <= 1'b0;
      end else if (!stall[4]) begin
        {pc_q, we_q, waddr_q, wdata_q, op_q, lo_q} <= mem_to_wb_bus;
        first_q <= 1'b1;
      end else begin
        first_q <= 1'b0;
      end
    end
  end

  logic [31:0] word;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] wb_data;

  always_comb begin
    word  = first_q ? data_sram_rdata : hold_q;
    sel_b = word[7:0];
    unique case (lo_q)
      2'd0: sel_b = word[7:0];
      2'd1: sel_b = word[15:8];
      2'd2: sel_b = word[23:16];
      2'd3: sel_b = word[31:24];
    endcase
    sel_h   = lo_q[1] ? word[31:16] : word[15:0];
    wb_data = wdata_q;
    unique case (op_q)
      3'b001:  wb_data = {{24{sel_b[7]}}, sel_b};
      3'b010:  wb_data = {24'd0, sel_b};
      3'b011:  wb_data = {{16{sel_h[15]}}, sel_h};
      3'b100:  wb_data = {16'd0, sel_h};
      3'b101:  wb_data = word;
      default: wb_data = wdata_q;
    endcase
  end

  assign rf_we             = we_q;
  assign rf_waddr          = waddr_q;
  assign rf_wdata          = wb_data;
  assign wb_to_id_bus      = {we_q, waddr_q, wb_data};
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = {4{we_q}};
  assign debug_wb_rf_wnum  = waddr_q;
  assign debug_wb_rf_wdata = wb_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed cases plus random traffic
// against a slot-level reference model with a scoreboard queue.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [74:0] mem_to_wb_bus;
  logic [31:0] data_sram_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [37:0] wb_to_id_bus;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_to_wb_bus(mem_to_wb_bus), .data_sram_rdata(data_sram_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_to_id_bus(wb_to_id_bus), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // model: the instruction sitting in WB and the word bound to it
  logic [74:0] m_slot = '0;
  logic        m_first = 1'b0;
  logic [31:0] m_word = '0;
  logic        m_valid = 1'b0;

  function automatic logic [31:0] ext(logic [74:0] s, logic [31:0] w);
    int unsigned op, lo, b, h;
    op = s[4:2];
    lo = s[1:0];
    b  = (w >> (8 * lo)) & 32'hFF;
    h  = (w >> (16 * (lo / 2))) & 32'hFFFF;
    case (op)
      1: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      2: return b;
      3: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      4: return h;
      5: return w;
      default: return s[36:5];
    endcase
  endfunction

  function automatic logic [74:0] mk(logic [31:0] pc, logic we,
      logic [4:0] wa, logic [31:0] wd, logic [2:0] op, logic [1:0] lo);
    return {pc, we, wa, wd, op, lo};
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic cycle(logic r, logic [5:0] st, logic fl, logic [74:0] bus,
      logic [31:0] rd, logic dochk = 0, logic [64:0] want = '0,
      string nm = "");
    exp_t e;
    rst = r; stall = st; flush = fl;
    mem_to_wb_bus = bus; data_sram_rdata = rd;
    if (m_valid) begin
      e.pc    = m_slot[74:43];
      e.we    = m_slot[42];
      e.waddr = m_slot[41:37];
      e.wdata = ext(m_slot, m_first ? rd : m_word);
      q.push_back(e);
    end
    if (dochk) begin
      #3;
      chk(nm, {63'd0, rf_we, debug_wb_pc, rf_wdata}, {63'd0, want});
    end
    @(posedge clk);
    if (r) begin
      m_slot = '0; m_first = 0; m_word = '0; m_valid = 1;
    end else begin
      if (m_first) m_word = rd;
      if (fl || (st[4] && !st[5])) begin
        m_slot = '0; m_first = 0;
      end else if (!st[4]) begin
        m_slot = bus; m_first = 1;
      end else begin
        m_first = 0;
      end
    end
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("wport", {rf_we, rf_waddr, rf_wdata},
            {e.we, e.waddr, e.wdata});
        chk("bypass", wb_to_id_bus, {e.we, e.waddr, e.wdata});
        chk("trace_pc", debug_wb_pc, e.pc);
        chk("trace", {debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata},
            {{4{e.we}}, e.waddr, e.wdata});
      end
    end
  end

  localparam logic [31:0] RD = 32'h80FF7F01;

  initial begin : driver
    logic [74:0] z;
    z = '0;
    rst = 1; stall = 0; flush = 0; mem_to_wb_bus = '0; data_sram_rdata = '0;
    @(posedge clk); #1;
    cycle(1, 0, 0, z, 0);
    cycle(1, 0, 0, z, 0);
    cycle(0, 6'b010000, 0, z, 0, 1, 65'd0, "reset");

    cycle(0, 0, 0, mk(32'hBFC00010, 1, 8, 32'h1234, 0, 0), 0);
    cycle(0, 0, 0, mk(32'h100, 1, 3, 0, 3'b001, 3), 0, 1,
          {1'b1, 32'hBFC00010, 32'h1234}, "alu");
    cycle(0, 0, 0, mk(32'h104, 1, 4, 0, 3'b010, 1), RD, 1,
          {1'b1, 32'h100, 32'hFFFFFF80}, "lb");
    cycle(0, 0, 0, mk(32'h108, 1, 5, 0, 3'b011, 2), RD, 1,
          {1'b1, 32'h104, 32'h0000007F}, "lbu");
    cycle(0, 0, 0, mk(32'h10C, 1, 6, 0, 3'b100, 0), RD, 1,
          {1'b1, 32'h108, 32'hFFFF80FF}, "lh");
    cycle(0, 0, 0, mk(32'h110, 1, 7, 0, 3'b101, 2), RD, 1,
          {1'b1, 32'h10C, 32'h00007F01}, "lhu");
    cycle(0, 6'b110000, 0, z, RD, 1,
          {1'b1, 32'h110, RD}, "lw");
    for (int i = 0; i < 3; i++)
      cycle(0, 6'b110000, 0, z, 32'hDEADBEEF, 1,
            {1'b1, 32'h110, RD}, "lw_stall");
    cycle(0, 6'b010000, 0, mk(32'h200, 1, 9, 32'h55, 0, 0), 32'hDEADBEEF);
    cycle(0, 0, 0, z, 0, 1, 65'd0, "mem_stall_bubble");
    cycle(0, 0, 1, mk(32'h204, 1, 10, 32'h66, 0, 0), 0);
    cycle(0, 0, 0, z, 0, 1, 65'd0, "flush_bubble");
    cycle(0, 0, 0, mk(32'h208, 1, 0, 32'h77, 0, 0), 0);
    cycle(0, 6'b110000, 1, z, 0, 1, {1'b1, 32'h208, 32'h77}, "r0_pass");
    cycle(0, 0, 0, z, 0, 1, 65'd0, "flush_over_stall");

    for (int i = 0; i < 600; i++) begin
      logic [5:0] st;
      st = 6'($urandom);
      if ($urandom_range(0, 2) == 0) st[5:4] = 2'b00;
      cycle($urandom_range(0, 49) == 0, st, $urandom_range(0, 9) == 0,
            mk($urandom, 1'($urandom), 5'($urandom), $urandom,
               3'($urandom), 2'($urandom)),
            $urandom);
    end

    repeat (3) @(negedge clk);
    chk("drain", 128'(q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
